spi_frame_decoder: RTL
======================

Name: spi_frame_decoder

Overview:
Consumes the byte stream from the SPI receive stage and parses host command frames. Turns frames into write strobes for the weight and activation buffers and a start pulse for the quantized linear-layer core. Sits between the SPI byte receiver and the accelerator's buffer/control logic. All logic runs in the clk domain.

Parameters:
ADDR_W, 10, buffer word-address width (1..16)
DATA_WIDTH, 8, byte width; fixed 8, kept for symmetry with the receiver

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
byte_in  in  8  received byte; valid only with byte_valid
byte_valid  in  1  single-cycle pulse, one per received byte
cs_n  in  1  raw SPI chip select (active low), asynchronous to clk
wr_en  out  1  buffer write strobe, one cycle per payload byte
wr_sel  out  1  0 = weight buffer, 1 = activation buffer
wr_addr  out  ADDR_W  buffer write address
wr_data  out  8  buffer write data
start  out  1  one-cycle pulse: launch computation
frame_err  out  1  one-cycle pulse on any frame error
busy  out  1  high while not in IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; addr, count and checksum registers 0.
- cs_n passes through a 2-flop synchronizer (cs_s). Only the synchronized value is used.
- Frame format: OPC, then for LOAD_W (0x01) or LOAD_A (0x02): LEN, ADDR_HI, ADDR_LO, LEN+1 payload bytes, then CSUM. RUN (0x03) is OPC then CSUM.
- LEN is minus-one encoded: 0x00 means 1 byte, 0xFF means 256 bytes.
- CSUM = XOR of all preceding bytes in the frame.
- Start address = {ADDR_HI, ADDR_LO}[ADDR_W-1:0]; upper bits are ignored.
- FSM states: IDLE, LEN, AHI, ALO, PAYLOAD, CSUM, DISCARD.
- FSM advances only on byte_valid. IDLE transitions on opcode:
  - 0x01/0x02 -> LEN
  - 0x03 -> CSUM
  - other -> DISCARD, with frame_err pulse
- LEN -> AHI -> ALO -> PAYLOAD -> CSUM -> IDLE. PAYLOAD is left after count reaches LEN.
- PAYLOAD: wr_en asserts the cycle after byte_valid, with wr_data = byte, wr_addr = current addr and wr_sel from the opcode. addr then increments modulo 2^ADDR_W; wrap-around is silent.
- Writes are not retracted on a bad checksum. The host must resend.
- CSUM: on match, a RUN frame pulses start the cycle after byte_valid. On mismatch, frame_err pulses and start is suppressed. Either way the FSM returns to IDLE.
- DISCARD: ignores bytes until cs_s goes high.
- cs_s high while in any state: FSM goes to IDLE.
  - If the state is not IDLE or DISCARD (truncated frame), frame_err pulses.
  - If the abort coincides with byte_valid, the abort wins and the byte is dropped.
- Back-to-back frames within one CS assertion are legal: the next byte after CSUM is an OPC.
- wr_en, start and frame_err are each at most one cycle. start and frame_err are never asserted together.
- Async reset mid-frame: immediate return to reset state; no pulses emitted.

Optional Feature:
CHECKSUM_EN
- Defined: frame includes the CSUM byte and is verified as above.
- Undefined: no CSUM byte and no CSUM state. PAYLOAD returns to IDLE after the last byte. RUN pulses start the cycle after the opcode byte_valid. frame_err covers only bad opcode and truncation.

Decomposition:
- Package spi_frame_pkg holds:
  - opcode constants OPC_LOAD_W, OPC_LOAD_A, OPC_RUN
  - the state enum typedef
  - the WR_SEL_W / WR_SEL_A constants
- Sub-module cs_sync: 2-flop synchronizer with async reset to 1 (deasserted).

Test Plan:
1. LOAD_W, LEN=0x02, addr 0x0010, payload AA BB CC, valid CSUM -> three wr_en pulses at addr 0x010/011/012 with data AA/BB/CC, wr_sel=0, no frame_err.
2. LOAD_A at addr 0x03FE, LEN=0x02 (ADDR_W=10) -> writes at 0x3FE, 0x3FF, 0x000 (wrap), wr_sel=1.
3. RUN 0x03 with CSUM 0x03 -> start pulses once. Repeat with CSUM 0x00 -> frame_err pulses, no start.
4. Opcode 0x7F followed by 5 bytes, then cs_n high -> one frame_err, no wr_en, busy falls after CS release. The next frame decodes normally.
5. LOAD_W with LEN=0x04, cs_n raised after 2 payload bytes -> 2 writes, frame_err pulse, FSM back in IDLE.
6. Two RUN frames back-to-back in one CS assertion -> two start pulses. Build without CHECKSUM_EN: a single 0x03 byte -> start one cycle after byte_valid.

Source files
------------

// File: rtl/spi_frame_pkg.sv
// Shared opcodes, buffer-select codes and FSM state encoding for the SPI frame decoder.
// The CSUM state exists only when CHECKSUM_EN is defined.
package spi_frame_pkg;

  localparam logic [7:0] OPC_LOAD_W = 8'h01;
  localparam logic [7:0] OPC_LOAD_A = 8'h02;
  localparam logic [7:0] OPC_RUN    = 8'h03;

  localparam logic WR_SEL_W = 1'b0;
  localparam logic WR_SEL_A = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_AHI,
    ST_ALO,
    ST_PAYLOAD,
    ST_DISCARD
`ifdef CHECKSUM_EN
    , ST_CSUM
`endif
  } state_e;

endpackage

// File: rtl/spi_frame_decoder_cs_sync.sv
// Two-flop synchronizer for the raw SPI chip select.
// It resets to 1 so that the decoder sees "deselected" until the real level arrives.
module cs_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/spi_frame_decoder.sv
// Parses host command frames from the SPI byte stream into buffer writes and a run pulse.
// Define CHECKSUM_EN to require and verify a trailing XOR checksum byte on every frame.
module spi_frame_decoder
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  input  logic                  cs_n,
  output logic                  wr_en,
  output logic                  wr_sel,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  start,
  output logic                  frame_err,
  output logic                  busy
);

  logic cs_s;

  cs_sync u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (cs_n),
    .sync_o  (cs_s)
  );

  state_e                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            ahi_q, ahi_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  sel_q, sel_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  start_q, start_d;
  logic                  err_q, err_d;
`ifdef CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  is_run_q, is_run_d;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    ahi_d     = ahi_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
`ifdef CHECKSUM_EN
    csum_d    = csum_q;
    is_run_d  = is_run_q;
`endif
    // A deselect aborts whatever is in flight, including a byte arriving this cycle.
    if (cs_s) begin
      state_d = ST_IDLE;
      if (state_q != ST_IDLE && state_q != ST_DISCARD) err_d = 1'b1;
    end else if (byte_valid) begin
`ifdef CHECKSUM_EN
      csum_d = csum_q ^ byte_in;
`endif
      case (state_q)
        ST_IDLE: begin
`ifdef CHECKSUM_EN
          csum_d   = byte_in;
          is_run_d = 1'b0;
`endif
          case (byte_in)
            OPC_LOAD_W: begin sel_d = WR_SEL_W; state_d = ST_LEN; end
            OPC_LOAD_A: begin sel_d = WR_SEL_A; state_d = ST_LEN; end
            OPC_RUN: begin
`ifdef CHECKSUM_EN
              is_run_d = 1'b1;
              state_d  = ST_CSUM;
`else
              start_d  = 1'b1;
`endif
            end
            default: begin
              state_d = ST_DISCARD;
              err_d   = 1'b1;
            end
          endcase
        end
        ST_LEN: begin len_d = byte_in; state_d = ST_AHI; end
        ST_AHI: begin ahi_d = byte_in; state_d = ST_ALO; end
        ST_ALO: begin
          addr_d  = ADDR_W'({ahi_q, byte_in});
          cnt_d   = 8'd0;
          state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          wr_en_d   = 1'b1;
          wr_sel_d  = sel_q;
          wr_addr_d = addr_q;
          wr_data_d = byte_in;
          addr_d    = addr_q + ADDR_W'(1);
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == len_q) begin
`ifdef CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef CHECKSUM_EN
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (byte_in != csum_q) err_d = 1'b1;
          else if (is_run_q)     start_d = 1'b1;
        end
`endif
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      ahi_q     <= '0;
      addr_q    <= '0;
      sel_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q    <= '0;
      is_run_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      ahi_q     <= ahi_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      err_q     <= err_d;
`ifdef CHECKSUM_EN
      csum_q    <= csum_d;
      is_run_q  <= is_run_d;
`endif
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign start     = start_q;
  assign frame_err = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
